// File: rtl/multibyte_add_sequencer.sv
// multibyte_add_sequencer: 8*NBYTES-bit add done one byte per cycle, LSB first, through two chained 8-bit ripple adders.
module ripple_carry_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s,
    output logic       co
);
    logic [8:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[8];
endmodule

module multibyte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [8*NBYTES-1:0] a_in,
    input  logic [8*NBYTES-1:0] b_in,
    input  logic                cin_in,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [8*NBYTES-1:0] sum_out,
    output logic                carry_out,
    output logic                zero_out,
    output logic                busy
);
    localparam int W  = 8 * NBYTES;
    localparam int KW = NBYTES > 1 ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_reg, b_reg;
    logic [KW-1:0] k;
    logic          carry_reg;
    logic [7:0]    a_byte, b_byte, s1, s2;
    logic          c1, c2, last;

    assign last = k == KW'(NBYTES - 1);

    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (k == KW'(i)) begin
                a_byte = a_reg[8*i +: 8];
                b_byte = b_reg[8*i +: 8];
            end
        end
    end

    ripple_carry_adder u_ab (.a(a_byte), .b(b_byte),            .s(s1), .co(c1));
    ripple_carry_adder u_cy (.a(s1),     .b({7'b0, carry_reg}), .s(s2), .co(c2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start_valid  ? RUN  : IDLE;
            RUN:     state_nx = last         ? DONE : RUN;
            DONE:    state_nx = result_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // c1 and c2 can never both be set, so OR-ing them gives the byte carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else if (state == IDLE && start_valid) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            carry_reg <= cin_in;
            k         <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NBYTES; i++)
                if (k == KW'(i)) sum_out[8*i +: 8] <= s2;
            carry_reg <= c1 | c2;
            if (last) carry_out <= c1 | c2;
            else      k <= k + KW'(1);
        end
    end

    assign start_ready  = state == IDLE;
    assign result_valid = state == DONE;
    assign busy         = state != IDLE;
    assign zero_out     = ~|sum_out;
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// tb_multibyte_add_sequencer: checks an NBYTES=4 and an NBYTES=1 instance against a transaction-level model.
module tb_multibyte_add_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        sv_i, rr_i, cin_i;
    logic [1:0][31:0]  a_i, b_i;
    logic [1:0]        sr_o, rv_o, bz_o, co_o, z_o;
    logic [1:0][31:0]  so;

    multibyte_add_sequencer #(.NBYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv_i[0]), .start_ready(sr_o[0]),
        .a_in(a_i[0]), .b_in(b_i[0]), .cin_in(cin_i[0]), .result_valid(rv_o[0]),
        .result_ready(rr_i[0]), .sum_out(so[0]), .carry_out(co_o[0]), .zero_out(z_o[0]), .busy(bz_o[0]));

    multibyte_add_sequencer #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv_i[1]), .start_ready(sr_o[1]),
        .a_in(a_i[1][7:0]), .b_in(b_i[1][7:0]), .cin_in(cin_i[1]), .result_valid(rv_o[1]),
        .result_ready(rr_i[1]), .sum_out(so[1][7:0]), .carry_out(co_o[1]), .zero_out(z_o[1]), .busy(bz_o[1]));
    assign so[1][31:8] = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s dut%0d got=%0h want=%0h", nm, d, got, want);
        end
    endtask

    function automatic int nbf(input int d);
        return d == 0 ? 4 : 1;
    endfunction

    // Transaction model: sum = (A+B+cin) mod 2^W, result shown NBYTES cycles after accept, held until taken.
    int               cyc = 0;
    logic [1:0]       m_idle, m_done, m_co, p_co;
    logic [1:0][31:0] m_sum, p_sum;
    int               m_rem[2];
    int               last_acc[2], prev_acc[2];
    logic [31:0]      mk;
    logic [32:0]      full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = '1;
            m_done = '0;
            m_sum  = '0;
            m_co   = '0;
            for (int d = 0; d < 2; d++) m_rem[d] = 0;
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (m_idle[d]) begin
                    if (sv_i[d]) begin
                        mk       = 32'hFFFF_FFFF >> (32 - 8 * nbf(d));
                        full     = {1'b0, a_i[d] & mk} + {1'b0, b_i[d] & mk} + 33'(cin_i[d]);
                        p_sum[d] = full[31:0] & mk;
                        p_co[d]  = full[8 * nbf(d)];
                        m_idle[d] = 1'b0;
                        m_rem[d]  = nbf(d);
                        prev_acc[d] = last_acc[d];
                        last_acc[d] = cyc;
                    end
                end else if (m_rem[d] > 0) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) begin
                        m_done[d] = 1'b1;
                        m_sum[d]  = p_sum[d];
                        m_co[d]   = p_co[d];
                    end
                end else if (rr_i[d]) begin
                    m_done[d] = 1'b0;
                    m_idle[d] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk("start_ready", d, sr_o[d], m_idle[d]);
                chk("busy", d, bz_o[d], !m_idle[d]);
                chk("result_valid", d, rv_o[d], m_done[d]);
                if (m_done[d]) begin
                    chk("sum_out", d, so[d], m_sum[d]);
                    chk("carry_out", d, co_o[d], m_co[d]);
                    chk("zero_out", d, z_o[d], m_sum[d] == 0);
                end
            end
        end
    end

    task automatic wait_idle(input int d);
        @(negedge clk);
        for (int i = 0; i < 50 && !sr_o[d]; i++) @(negedge clk);
        chk("idle_timeout", d, sr_o[d], 1);
    endtask

    task automatic start_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic c, output int t0);
        wait_idle(d);
        a_i[d] = a; b_i[d] = b; cin_i[d] = c; sv_i[d] = 1'b1;
        @(negedge clk);
        t0 = cyc;
        sv_i[d] = 1'b0;
    endtask

    task automatic wait_res(input int d, output int t);
        for (int i = 0; i < 50 && !rv_o[d]; i++) @(negedge clk);
        chk("result_timeout", d, rv_o[d], 1);
        t = cyc;
    endtask

    task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic [31:0] es, input logic ec, input int elat);
        int t0, t1;
        start_op(d, a, b, c, t0);
        wait_res(d, t1);
        chk("op_sum", d, so[d], es);
        chk("op_carry", d, co_o[d], ec);
        chk("op_zero", d, z_o[d], es == 0);
        chk("op_latency", d, t1 - t0, elat);
        chk("model_sum", d, m_sum[d], es);
    endtask

    task automatic b2b(input int d, input logic [31:0] a1, input logic [31:0] b1, input logic c1,
                       input logic [31:0] a2, input logic [31:0] b2, input logic c2,
                       input logic [31:0] e1, input logic f1, input logic [31:0] e2, input logic f2);
        int got = 0;
        bit sw = 0, idl = 0, dropped = 0;
        wait_idle(d);
        rr_i[d] = 1'b1;
        a_i[d] = a1; b_i[d] = b1; cin_i[d] = c1; sv_i[d] = 1'b1;
        for (int i = 0; i < 40 && got < 2; i++) begin
            @(negedge clk);
            if (rv_o[d]) begin
                chk("b2b_sum", d, so[d], got == 0 ? e1 : e2);
                chk("b2b_carry", d, co_o[d], got == 0 ? f1 : f2);
                got++;
            end
            if (!sw && bz_o[d]) begin
                a_i[d] = a2; b_i[d] = b2; cin_i[d] = c2; sw = 1;
            end else if (sw && sr_o[d]) begin
                idl = 1;
            end else if (idl && bz_o[d] && !dropped) begin
                sv_i[d] = 1'b0; dropped = 1;
            end
        end
        sv_i[d] = 1'b0;
        chk("b2b_count", d, got, 2);
        chk("b2b_spacing", d, last_acc[d] - prev_acc[d], nbf(d) + 2);
    endtask

    initial begin
        int t0, t1;
        sv_i = '0; rr_i = '1; cin_i = '0; a_i = '0; b_i = '0;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_start_ready", d, sr_o[d], 1);
            chk("rst_result_valid", d, rv_o[d], 0);
            chk("rst_busy", d, bz_o[d], 0);
            chk("rst_sum", d, so[d], 0);
            chk("rst_carry", d, co_o[d], 0);
            chk("rst_zero", d, z_o[d], 1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 4);
        do_op(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 4);
        do_op(0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 4);
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 4);

        wait_idle(0);
        rr_i[0] = 1'b0;
        do_op(0, 32'h3, 32'h5, 1'b0, 32'h8, 1'b0, 4);
        repeat (10) begin
            @(negedge clk);
            chk("bp_sum", 0, so[0], 32'h8);
            chk("bp_start_ready", 0, sr_o[0], 0);
            chk("bp_busy", 0, bz_o[0], 1);
            chk("bp_valid", 0, rv_o[0], 1);
            sv_i[0] = ~sv_i[0];
            a_i[0] = $urandom;
            b_i[0] = $urandom;
            cin_i[0] = 1'($urandom);
        end
        @(negedge clk);
        rr_i[0] = 1'b1; sv_i[0] = 1'b1; a_i[0] = 32'h10; b_i[0] = 32'h20; cin_i[0] = 1'b0;
        @(negedge clk);
        chk("bp_release_ready", 0, sr_o[0], 1);
        chk("bp_release_valid", 0, rv_o[0], 0);
        rr_i[0] = 1'b0;
        @(negedge clk);
        chk("bp_reaccept_busy", 0, bz_o[0], 1);
        sv_i[0] = 1'b0;
        wait_res(0, t1);
        chk("bp_next_sum", 0, so[0], 32'h30);
        rr_i[0] = 1'b1;

        start_op(0, 32'h1111_1111, 32'h2222_2222, 1'b0, t0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 0, rv_o[0], 0);
        chk("mid_rst_busy", 0, bz_o[0], 0);
        chk("mid_rst_sum", 0, so[0], 0);
        chk("mid_rst_ready", 0, sr_o[0], 1);
        chk("mid_rst_zero", 0, z_o[0], 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 4);

        b2b(0, 32'h0102_0304, 32'h1020_3040, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0,
            32'h1122_3344, 1'b0, 32'h0000_0000, 1'b1);

        do_op(1, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1);
        b2b(1, 32'hFF, 32'h01, 1'b0, 32'h7F, 32'h01, 1'b1, 32'h00, 1'b1, 32'h81, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end
endmodule
